// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared sizing defaults and master ids for the on-chip RAM arbiter.
package onchip_mem_arbiter_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 10240;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/onchip_mem_arbiter_if.sv
// Avalon-MM style requester bus between one master and the arbiter.
interface onchip_mem_arbiter_if #(
    parameter int unsigned ADDR_W = onchip_mem_arbiter_pkg::ADDR_W,
    parameter int unsigned DATA_W = onchip_mem_arbiter_pkg::DATA_W
);
    localparam int unsigned BE_W = DATA_W / 8;

    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0]   byteenable;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic              waitrequest;
    logic [DATA_W-1:0] readdata;
    logic              readdatavalid;

    modport master (
        output address, byteenable, read, write, writedata,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, byteenable, read, write, writedata,
        output waitrequest, readdata, readdatavalid
    );

endinterface

// File: rtl/onchip_mem_arbiter_rr_arb2.sv
// Two-input round-robin grant with the last-granted register.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);
    import onchip_mem_arbiter_pkg::*;

    logic       r_last;
    logic [1:0] w_gnt;

    // Lone requester wins; on a tie the master not granted last wins; nothing during reset
    always_comb begin
        w_gnt = 2'b00;
        if (reset_n) begin
            case (i_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = (r_last == M1) ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign o_gnt = w_gnt;

    // Remember who was granted most recently; M1 after reset so M0 takes the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last <= M1;
        end else if (|w_gnt) begin
            r_last <= w_gnt[1];
        end
    end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares the single-port on-chip RAM between two requesters, returns read data
// to its issuer one cycle later and flags out-of-range accesses.
module onchip_mem_arbiter #(
    parameter int unsigned ADDR_W = onchip_mem_arbiter_pkg::ADDR_W,
    parameter int unsigned DATA_W = onchip_mem_arbiter_pkg::DATA_W,
    parameter int unsigned DEPTH  = onchip_mem_arbiter_pkg::DEPTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    onchip_mem_arbiter_if.slave   m0,
    onchip_mem_arbiter_if.slave   m1,
    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    output logic                  ram_clken,
    input  logic [DATA_W-1:0]     ram_readdata,
    output logic                  err_oor,
    input  logic                  err_clr
);
    import onchip_mem_arbiter_pkg::*;

    localparam int unsigned BE_W = DATA_W / 8;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_any;
    logic              w_sel;
    logic              w_rd;
    logic              w_wr;
    logic              w_oor;
    logic [ADDR_W-1:0] w_addr;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;
    logic              w_vld0;
    logic              w_vld1;

    logic              r_rd_pend;
    logic              r_rd_owner;
    logic              r_rd_oor;
    logic              r_err_oor;

    assign w_req = {m1.read | m1.write, m0.read | m0.write};

    rr_arb2 u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .i_req   (w_req),
        .o_gnt   (w_gnt)
    );

    // Steer the granted master's command onto the RAM side; zeros when idle
    always_comb begin
        w_any   = |w_gnt;
        w_sel   = w_gnt[1];
        w_addr  = '0;
        w_be    = '0;
        w_wdata = '0;
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        if (w_gnt[0]) begin
            w_addr  = m0.address;
            w_be    = m0.byteenable;
            w_wdata = m0.writedata;
            w_rd    = m0.read;
            w_wr    = m0.write;
        end else if (w_gnt[1]) begin
            w_addr  = m1.address;
            w_be    = m1.byteenable;
            w_wdata = m1.writedata;
            w_rd    = m1.read;
            w_wr    = m1.write;
        end
        w_oor = w_any && (32'(w_addr) >= DEPTH);
    end

    // Out-of-range accesses are still granted but never reach the RAM
    assign ram_address    = w_addr;
    assign ram_byteenable = w_be;
    assign ram_writedata  = w_wdata;
    assign ram_chipselect = w_any & ~w_oor;
    assign ram_write      = w_wr & ~w_oor;
    assign ram_clken      = 1'b1;

    assign m0.waitrequest = w_req[0] & ~w_gnt[0];
    assign m1.waitrequest = w_req[1] & ~w_gnt[1];

    // Read return: valid only to the issuer, zero data for out-of-range reads
    assign w_rdata          = r_rd_oor ? '0 : ram_readdata;
    assign w_vld0           = r_rd_pend & (r_rd_owner == M0);
    assign w_vld1           = r_rd_pend & (r_rd_owner == M1);
    assign m0.readdatavalid = w_vld0;
    assign m1.readdatavalid = w_vld1;
    assign m0.readdata      = w_vld0 ? w_rdata : '0;
    assign m1.readdata      = w_vld1 ? w_rdata : '0;

    // Capture the granted read so its data can be routed back next cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_pend  <= 1'b0;
            r_rd_owner <= M0;
            r_rd_oor   <= 1'b0;
        end else begin
            r_rd_pend <= w_rd;
            if (w_rd) begin
                r_rd_owner <= w_sel;
                r_rd_oor   <= w_oor;
            end
        end
    end

    // Sticky out-of-range flag; a new error beats a simultaneous clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err_oor <= 1'b0;
        end else if (w_oor) begin
            r_err_oor <= 1'b1;
        end else if (err_clr) begin
            r_err_oor <= 1'b0;
        end
    end

    assign err_oor = r_err_oor;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Scoreboard bench for onchip_mem_arbiter with a behavioural 1-cycle RAM.
module tb_onchip_mem_arbiter;

    localparam int unsigned DEPTH = onchip_mem_arbiter_pkg::DEPTH;

    typedef struct {
        int          owner;
        logic [31:0] data;
        int          cyc;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        err_clr = 1'b0;
    logic        err_oor;
    logic [13:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic        ram_chipselect;
    logic        ram_write;
    logic [31:0] ram_writedata;
    logic        ram_clken;
    logic [31:0] ram_readdata = '0;
    logic [31:0] ram_mem [0:DEPTH-1];

    int  n_checks = 0;
    int  n_fails  = 0;
    int  cyc      = 0;
    sb_t sb_q[$];
    logic acc_cs;
    logic acc_wr;

    onchip_mem_arbiter_if m0_if ();
    onchip_mem_arbiter_if m1_if ();

    onchip_mem_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .m0             (m0_if),
        .m1             (m1_if),
        .ram_address    (ram_address),
        .ram_byteenable (ram_byteenable),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_writedata  (ram_writedata),
        .ram_clken      (ram_clken),
        .ram_readdata   (ram_readdata),
        .err_oor        (err_oor),
        .err_clr        (err_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    // Behavioural single-port RAM, 1-cycle read latency
    always @(posedge clk) begin
        if (ram_clken && ram_chipselect && (32'(ram_address) < DEPTH)) begin
            if (ram_write) ram_mem[ram_address] <= merge(ram_mem[ram_address], ram_writedata, ram_byteenable);
            else           ram_readdata <= ram_mem[ram_address];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Pop and compare each returned read against the scoreboard
    always @(negedge clk) begin
        logic [1:0]  vld;
        logic [31:0] rd [2];
        sb_t         e;
        if (reset_n) begin
            vld   = {m1_if.readdatavalid, m0_if.readdatavalid};
            rd[0] = m0_if.readdata;
            rd[1] = m1_if.readdata;
            for (int n = 0; n < 2; n++) begin
                if (vld[n]) begin
                    if (sb_q.size() == 0) begin
                        check_eq($sformatf("unexpected_valid_m%0d", n), 32'(vld[n]), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check_eq($sformatf("rd_owner_m%0d", n), n, e.owner);
                        check_eq($sformatf("rd_data_m%0d", n), rd[n], e.data);
                        check_eq($sformatf("rd_latency_m%0d", n), cyc, e.cyc + 1);
                    end
                end else begin
                    check_eq($sformatf("rdata_idle_m%0d", n), rd[n], 32'd0);
                end
            end
        end
    end

    task automatic drive(input int m, input logic rd, input logic wr, input logic [13:0] a,
                         input logic [3:0] be, input logic [31:0] d);
        if (m == 0) begin
            m0_if.read = rd; m0_if.write = wr; m0_if.address = a;
            m0_if.byteenable = be; m0_if.writedata = d;
        end else begin
            m1_if.read = rd; m1_if.write = wr; m1_if.address = a;
            m1_if.byteenable = be; m1_if.writedata = d;
        end
    endtask

    task automatic drive_idle(input int m);
        drive(m, 1'b0, 1'b0, '0, '0, '0);
    endtask

    function automatic logic wreq(input int m);
        return (m == 0) ? m0_if.waitrequest : m1_if.waitrequest;
    endfunction

    task automatic push_exp(input int m, input logic [31:0] d);
        sb_q.push_back('{owner: m, data: d, cyc: cyc});
    endtask

    // Single-master access: wait (bounded) for accept, record expected read data
    task automatic access(input int m, input logic wr, input logic [13:0] a,
                          input logic [3:0] be, input logic [31:0] d, input logic [31:0] exp);
        int n;
        @(posedge clk); #1;
        drive(m, !wr, wr, a, be, d);
        n = 0;
        @(negedge clk);
        while (wreq(m) && n < 16) begin
            n++;
            @(negedge clk);
        end
        check_eq($sformatf("accept_m%0d", m), 32'(wreq(m)), 32'd0);
        acc_cs = ram_chipselect;
        acc_wr = ram_write;
        if (!wr && !wreq(m)) push_exp(m, exp);
        @(posedge clk); #1;
        drive_idle(m);
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_cs",    32'(ram_chipselect), 32'd0);
        check_eq("rst_we",    32'(ram_write), 32'd0);
        check_eq("rst_addr",  32'(ram_address), 32'd0);
        check_eq("rst_be",    32'(ram_byteenable), 32'd0);
        check_eq("rst_wdata", ram_writedata, 32'd0);
        check_eq("rst_clken", 32'(ram_clken), 32'd1);
        check_eq("rst_vld",   32'({m1_if.readdatavalid, m0_if.readdatavalid}), 32'd0);
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        reset_n = 1'b0;
        sb_q.delete();
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs();
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, with a request present to prove the RAM side stays quiet
        drive_idle(1);
        drive(0, 1'b0, 1'b1, 14'h0005, 4'hF, 32'h5555_AAAA);
        repeat (2) begin
            @(negedge clk);
            check_reset_outputs();
            check_eq("rst_err", 32'(err_oor), 32'd0);
        end
        drive_idle(0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("idle_wr_m0", 32'(m0_if.waitrequest), 32'd0);
        check_eq("idle_wr_m1", 32'(m1_if.waitrequest), 32'd0);
        check_eq("idle_cs",    32'(ram_chipselect), 32'd0);

        // m0 write then read back
        access(0, 1'b1, 14'h0010, 4'hF, 32'hA5A5_1234, '0);
        check_eq("t1_wr_cs", 32'(acc_cs), 32'd1);
        check_eq("t1_wr_we", 32'(acc_wr), 32'd1);
        access(0, 1'b0, 14'h0010, 4'hF, '0, 32'hA5A5_1234);
        repeat (2) @(posedge clk);
        check_eq("t1_no_err", 32'(err_oor), 32'd0);

        // m1 byte-lane write over a full word
        access(1, 1'b1, 14'h0020, 4'hF, 32'h1122_3344, '0);
        access(1, 1'b1, 14'h0020, 4'h2, 32'h0000_BB00, '0);
        access(1, 0, 14'h0020, 4'hF, '0, 32'h1122_BB44);

        // Out-of-range write and read
        access(0, 1'b1, 14'h2800, 4'hF, 32'hDEAD_BEEF, '0);
        check_eq("oor_wr_cs", 32'(acc_cs), 32'd0);
        check_eq("oor_wr_we", 32'(acc_wr), 32'd0);
        @(negedge clk);
        check_eq("oor_err_set", 32'(err_oor), 32'd1);
        access(0, 1'b0, 14'h0010, 4'hF, '0, 32'hA5A5_1234);
        access(0, 1'b0, 14'h3FFF, 4'hF, '0, 32'h0);
        check_eq("oor_rd_cs", 32'(acc_cs), 32'd0);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(negedge clk);
        check_eq("err_clr_sync", 32'(err_oor), 32'd1);
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check_eq("err_cleared", 32'(err_oor), 32'd0);
        // Clear and new error in the same cycle: set wins
        @(posedge clk); #1;
        err_clr = 1'b1;
        drive(0, 1'b1, 1'b0, 14'h3000, 4'hF, '0);
        @(negedge clk);
        check_eq("setwin_accept", 32'(m0_if.waitrequest), 32'd0);
        push_exp(0, 32'h0);
        @(posedge clk); #1;
        err_clr = 1'b0;
        drive_idle(0);
        @(negedge clk);
        check_eq("err_set_wins", 32'(err_oor), 32'd1);
        @(posedge clk); #1;
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        @(negedge clk);
        check_eq("err_cleared2", 32'(err_oor), 32'd0);

        // Reset while a read is pending discards its valid
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 14'h0010, 4'hF, '0);
        @(negedge clk);
        check_eq("pend_accept", 32'(m0_if.waitrequest), 32'd0);
        @(posedge clk); #1;
        drive_idle(0);
        reset_n = 1'b0;
        sb_q.delete();
        @(negedge clk);
        check_eq("pend_vld_rst", 32'({m1_if.readdatavalid, m0_if.readdatavalid}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("pend_vld_after", 32'({m1_if.readdatavalid, m0_if.readdatavalid}), 32'd0);
        // First tie after reset goes to m0, then m1
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 14'h0010, 4'hF, '0);
        drive(1, 1'b1, 1'b0, 14'h0010, 4'hF, '0);
        @(negedge clk);
        check_eq("tie_rst_m0", 32'(m0_if.waitrequest), 32'd0);
        check_eq("tie_rst_m1", 32'(m1_if.waitrequest), 32'd1);
        push_exp(0, 32'hA5A5_1234);
        @(posedge clk); #1;
        drive_idle(0);
        @(negedge clk);
        check_eq("tie_next_m1", 32'(m1_if.waitrequest), 32'd0);
        push_exp(1, 32'hA5A5_1234);
        @(posedge clk); #1;
        drive_idle(1);

        // Continuous contention: strict alternation, one grant every cycle
        access(0, 1'b1, 14'h0001, 4'hF, 32'h0000_0011, '0);
        access(1, 1'b1, 14'h0002, 4'hF, 32'h0000_0022, '0);
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 14'h0001, 4'hF, '0);
        drive(1, 1'b1, 1'b0, 14'h0002, 4'hF, '0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq($sformatf("alt_wr_m0_%0d", i), 32'(m0_if.waitrequest), (i % 2 == 1) ? 32'd1 : 32'd0);
            check_eq($sformatf("alt_wr_m1_%0d", i), 32'(m1_if.waitrequest), (i % 2 == 1) ? 32'd0 : 32'd1);
            check_eq($sformatf("alt_cs_%0d", i), 32'(ram_chipselect), 32'd1);
            if (i % 2 == 0) push_exp(0, 32'h0000_0011);
            else            push_exp(1, 32'h0000_0022);
            @(posedge clk); #1;
        end
        drive_idle(0);
        drive_idle(1);

        // Simultaneous write (m0) and read (m1) of the same word after reset
        apply_reset();
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b1, 14'h0100, 4'hF, 32'hCAFE_F00D);
        drive(1, 1'b1, 1'b0, 14'h0100, 4'hF, '0);
        @(negedge clk);
        check_eq("raw_m0_first", 32'(m0_if.waitrequest), 32'd0);
        check_eq("raw_m1_wait",  32'(m1_if.waitrequest), 32'd1);
        @(posedge clk); #1;
        drive_idle(0);
        @(negedge clk);
        check_eq("raw_m1_next", 32'(m1_if.waitrequest), 32'd0);
        push_exp(1, 32'hCAFE_F00D);
        @(posedge clk); #1;
        drive_idle(1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/onchip_mem_arbiter.md
# onchip_mem_arbiter

Two-requester round-robin arbiter that shares the single-port 10240×32 on-chip RAM between two Avalon-MM style masters. Sits between the masters and the RAM's slave port and drives its address, byteenable, chipselect, write, writedata and clken. Returns each read's data to the master that issued it, using the RAM's fixed 1-cycle read latency. Blocks out-of-range accesses and records them in a sticky error flag.

## Interface
Parameters:
- ADDR_W, 14, word-address width (RAM address port width)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- DEPTH, 10240, implemented words; addresses ≥ DEPTH are out of range

Ports (clock and reset first):
- clk  in  1  single clock for all logic
- reset_n  in  1  asynchronous, active-low reset
- mN_address  in  ADDR_W  requester N word address (N = 0, 1, same for every mN_ port)
- mN_byteenable  in  DATA_W/8  requester N byte lanes
- mN_read  in  1  read request
- mN_write  in  1  write request; read and write never both high
- mN_writedata  in  DATA_W  write data
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data, valid only with mN_readdatavalid
- mN_readdatavalid  out  1  one-cycle pulse per accepted read
- ram_address  out  ADDR_W  to RAM address
- ram_byteenable  out  DATA_W/8  to RAM byteenable
- ram_chipselect  out  1  to RAM chipselect
- ram_write  out  1  to RAM write
- ram_writedata  out  DATA_W  to RAM writedata
- ram_clken  out  1  to RAM clken; tied to 1
- ram_readdata  in  DATA_W  from RAM readdata, valid 1 cycle after address
- err_oor  out  1  sticky flag: an out-of-range access was accepted
- err_clr  in  1  synchronous clear of err_oor

## Operation
- A request is `mN_read | mN_write`. Arbitration is combinational each cycle. At most one grant per cycle.
- One requester active: it is granted.
- Both active: the one not granted last is granted. A 1-bit `last` register is updated on every grant. After reset `last` = 1, so m0 wins the first tie.
- Granted master: waitrequest = 0. Loser: waitrequest = 1 and must hold its request stable. An idle master sees waitrequest = 0 (don't-care).
- RAM outputs are a mux of the granted master's signals: ram_chipselect = grant, ram_write = granted write.
- With no grant, outputs are chipselect = 0, write = 0, and address/byteenable/writedata = 0.
- Out-of-range (address ≥ DEPTH):
  - The request is still granted.
  - ram_chipselect = 0 and ram_write = 0, so the write is dropped.
  - An out-of-range read returns 0.
  - err_oor sets on the following edge.
  - If err_clr and a new error occur in the same cycle, set wins.
- Read tracking: registers rd_pend (1 bit), rd_owner (1 bit) and rd_oor (1 bit) capture the granted read.
- In the next cycle, readdatavalid pulses for rd_owner. readdata = rd_oor ? 0 : ram_readdata. The other master's readdata = 0.
- Back-to-back reads, from the same or alternating masters, are accepted every cycle. Each read's data returns exactly 1 cycle after its grant.

## Timing
- Grant-to-RAM path: 0 cycles (combinational). Read data: 1 cycle after the accepted cycle.
- Write latency: written into RAM on the accept edge.
- Reset values: last = 1, rd_pend = 0, rd_owner = 0, rd_oor = 0, err_oor = 0.
- During reset: all mN_readdatavalid = 0 and all ram_* = 0 except ram_clken = 1.
- Reset asserted with a read pending: the pending readdatavalid is discarded and is not emitted after reset release.
- Throughput: 1 access per cycle in aggregate. Under continuous contention each master gets exactly 50%, alternating.

## Structure
- A shared package holds ADDR_W, DATA_W and DEPTH defaults, plus master-id localparams M0 = 0 and M1 = 1.
- Sub-module `rr_arb2`: 2-input round-robin grant logic plus the `last` register. Everything else stays in the top module.

## Test plan
- Single master m0 writes 0xA5A5_1234 to address 0x0010 with byteenable 0xF, then reads it back. Expected: readdatavalid one cycle after the read is accepted, readdata = 0xA5A5_1234, m1 sees no valid.
- Both masters read every cycle after reset (m0 address 0x0001, m1 address 0x0002, preloaded 0x11 and 0x22). Expected: grants alternate m0, m1, m0, …; each valid pulse goes to the correct master with the correct data; no cycle without a grant.
- m1 writes byteenable 0x2 with data 0x0000_BB00 over a word holding 0x1122_3344, then reads. Expected: readdata = 0x1122_BB44.
- m0 writes to address 10240 (0x2800), then reads 0x3FFF. Expected: ram_chipselect stays 0, err_oor = 1 after the first access, readdata = 0 with valid; an err_clr pulse returns err_oor to 0.
- m0 read accepted, then reset_n driven low in the next cycle before the clock edge. Expected: no readdatavalid; after release, a tie is won by m0.
- Simultaneous m0 write and m1 read to the same address 0x0100. Expected: m0 granted (first tie after reset) and m1 granted next cycle; m1 reads m0's new data.
